uartwb_arbiter: RTL and testbench

- Shares the single Wishbone wrapper transaction interface (wr/en/valid/addr/data) between NUM_REQ requesters.
- Requesters include the UART command controller plus future masters, such as a debug or DMA sequencer.
- Each requester posts one transaction at a time. The arbiter latches it, grants the wrapper round-robin, and returns read data or a timeout error to the owning requester.
- Sits between requester controllers and the WB wrapper.

---
 rtl/uartwb_pkg.sv | 15 +
 rtl/uartwb_rr_pick.sv | 33 +++
 rtl/uartwb_arbiter.sv | 142 ++++++++++++++
 tb/tb_uartwb_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uartwb_pkg.sv
// Shared definitions for the UART/Wishbone requester arbiter: FSM states and
// default wrapper bus widths.
package uartwb_pkg;

  localparam int unsigned DEF_ADDR_WID = 32;
  localparam int unsigned DEF_DATA_WID = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/uartwb_rr_pick.sv
// Combinational round-robin picker: first pending index at or after i_ptr,
// wrapping explicitly so non-power-of-2 requester counts work.
module uartwb_rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_WID = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_pending,
  input  logic [PTR_WID-1:0] i_ptr,
  output logic [PTR_WID-1:0] o_idx,
  output logic               o_any
);

  localparam int unsigned SW = PTR_WID + 1;

  logic [SW-1:0] w_pos;

  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    w_pos = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_pos = {1'b0, i_ptr} + SW'(i);
      if (w_pos >= SW'(NUM_REQ)) begin
        w_pos = w_pos - SW'(NUM_REQ);
      end
      if (!o_any && i_pending[w_pos[PTR_WID-1:0]]) begin
        o_any = 1'b1;
        o_idx = w_pos[PTR_WID-1:0];
      end
    end
  end

endmodule

// File: rtl/uartwb_arbiter.sv
// Shares one Wishbone wrapper transaction port between NUM_REQ requesters:
// latches one request per requester, grants round-robin, returns data/timeout.
module uartwb_arbiter
  import uartwb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned ADDR_WID = DEF_ADDR_WID,
  parameter int unsigned DATA_WID = DEF_DATA_WID,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic                        clk_i,
  input  logic                        nrst_i,
  input  logic [NUM_REQ-1:0]          req_en_i,
  input  logic [NUM_REQ-1:0]          req_wr_i,
  input  logic [NUM_REQ*ADDR_WID-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WID-1:0] req_data_i,
  output logic [NUM_REQ-1:0]          req_busy_o,
  output logic [NUM_REQ-1:0]          req_valid_o,
  output logic [NUM_REQ-1:0]          req_err_o,
  output logic [DATA_WID-1:0]         req_data_o,
  output logic                        wrapper_wr_o,
  output logic                        wrapper_en_o,
  input  logic                        wrapper_valid_i,
  output logic [ADDR_WID-1:0]         wrapper_addr_o,
  output logic [DATA_WID-1:0]         wrapper_data_o,
  input  logic [DATA_WID-1:0]         wrapper_data_i
);

  localparam int unsigned   PW       = $clog2(NUM_REQ);
  localparam int unsigned   CW       = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);

  state_t                r_state;
  logic [NUM_REQ-1:0]    r_pending;
  logic                  r_slot_wr   [NUM_REQ];
  logic [ADDR_WID-1:0]   r_slot_addr [NUM_REQ];
  logic [DATA_WID-1:0]   r_slot_data [NUM_REQ];
  logic [PW-1:0]         r_grant;
  logic [PW-1:0]         r_rr;
  logic [CW-1:0]         r_cnt;
  logic [NUM_REQ-1:0]    r_req_valid;
  logic [NUM_REQ-1:0]    r_req_err;
  logic [DATA_WID-1:0]   r_req_data;
  logic                  r_wb_wr;
  logic                  r_wb_en;
  logic [ADDR_WID-1:0]   r_wb_addr;
  logic [DATA_WID-1:0]   r_wb_data;
  logic [PW-1:0]         w_pick_idx;
  logic                  w_pick_any;

  uartwb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_WID (PW)
  ) u_pick (
    .i_pending (r_pending),
    .i_ptr     (r_rr),
    .o_idx     (w_pick_idx),
    .o_any     (w_pick_any)
  );

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      r_state     <= S_IDLE;
      r_pending   <= '0;
      r_grant     <= '0;
      r_rr        <= '0;
      r_cnt       <= '0;
      r_req_valid <= '0;
      r_req_err   <= '0;
      r_req_data  <= '0;
      r_wb_wr     <= 1'b0;
      r_wb_en     <= 1'b0;
      r_wb_addr   <= '0;
      r_wb_data   <= '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        r_slot_wr[k]   <= 1'b0;
        r_slot_addr[k] <= '0;
        r_slot_data[k] <= '0;
      end
    end else begin
      r_wb_en     <= 1'b0;
      r_req_valid <= '0;
      r_req_err   <= '0;
      r_req_data  <= '0;

      // A pulse from a requester that is still pending (incl. its completion cycle) is dropped.
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (req_en_i[k] && !r_pending[k]) begin
          r_pending[k]   <= 1'b1;
          r_slot_wr[k]   <= req_wr_i[k];
          r_slot_addr[k] <= req_addr_i[k*ADDR_WID +: ADDR_WID];
          r_slot_data[k] <= req_data_i[k*DATA_WID +: DATA_WID];
        end
      end

      case (r_state)
        S_IDLE: begin
          if (w_pick_any) begin
            r_grant   <= w_pick_idx;
            r_wb_wr   <= r_slot_wr[w_pick_idx];
            r_wb_addr <= r_slot_addr[w_pick_idx];
            r_wb_data <= r_slot_data[w_pick_idx];
            r_wb_en   <= 1'b1;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          if (wrapper_valid_i) begin
            r_req_valid[r_grant] <= 1'b1;
            r_req_data           <= wrapper_data_i;
            r_state              <= S_DONE;
          end else if ((TIMEOUT != 0) && (r_cnt == CNT_LAST)) begin
            r_req_valid[r_grant] <= 1'b1;
            r_req_err[r_grant]   <= 1'b1;
            r_state              <= S_DONE;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_pending[r_grant] <= 1'b0;
          r_rr               <= (r_grant == LAST_IDX) ? '0 : r_grant + 1'b1;
          r_cnt              <= '0;
          r_state            <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_busy_o     = r_pending;
  assign req_valid_o    = r_req_valid;
  assign req_err_o      = r_req_err;
  assign req_data_o     = r_req_data;
  assign wrapper_wr_o   = r_wb_wr;
  assign wrapper_en_o   = r_wb_en;
  assign wrapper_addr_o = r_wb_addr;
  assign wrapper_data_o = r_wb_data;

endmodule

// File: tb/tb_uartwb_arbiter.sv
// Scoreboard bench for uartwb_arbiter: directed scenarios plus random traffic,
// with a behavioural wrapper responder and arbitration model.
module tb_uartwb_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic            clk_i = 1'b0;
  logic            nrst_i = 1'b0;
  logic [N-1:0]    req_en_i = '0;
  logic [N-1:0]    req_wr_i = '0;
  logic [N*AW-1:0] req_addr_i = '0;
  logic [N*DW-1:0] req_data_i = '0;
  logic [N-1:0]    req_busy_o, req_valid_o, req_err_o;
  logic [DW-1:0]   req_data_o;
  logic            wrapper_wr_o, wrapper_en_o;
  logic            wrapper_valid_i = 1'b0;
  logic [AW-1:0]   wrapper_addr_o;
  logic [DW-1:0]   wrapper_data_o;
  logic [DW-1:0]   wrapper_data_i = '0;

  always #5 clk_i = ~clk_i;

  uartwb_arbiter #(
    .NUM_REQ  (N),
    .ADDR_WID (AW),
    .DATA_WID (DW),
    .TIMEOUT  (TO)
  ) dut (
    .clk_i           (clk_i),
    .nrst_i          (nrst_i),
    .req_en_i        (req_en_i),
    .req_wr_i        (req_wr_i),
    .req_addr_i      (req_addr_i),
    .req_data_i      (req_data_i),
    .req_busy_o      (req_busy_o),
    .req_valid_o     (req_valid_o),
    .req_err_o       (req_err_o),
    .req_data_o      (req_data_o),
    .wrapper_wr_o    (wrapper_wr_o),
    .wrapper_en_o    (wrapper_en_o),
    .wrapper_valid_i (wrapper_valid_i),
    .wrapper_addr_o  (wrapper_addr_o),
    .wrapper_data_o  (wrapper_data_o),
    .wrapper_data_i  (wrapper_data_i)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  typedef struct {
    int          owner;
    logic        err;
    logic [31:0] data;
    int          done_cyc;
    req_t        rq;
  } exp_t;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic [N-1:0] m_pending = '0;
  int           acc_cyc [N];
  int           m_rr = 0;
  int           last_done = -10;
  req_t         req_q [N][$];
  exp_t         exp_q [$];

  // Responder knobs for directed scenarios
  bit          knob_set = 0;
  int          knob_d = 1;
  bit          knob_fire = 1;
  logic [31:0] knob_data = '0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic drive(input logic [N-1:0] en, input logic [N-1:0] wr,
                       input logic [N*AW-1:0] a, input logic [N*DW-1:0] d);
    req_t r;
    req_en_i   = en;
    req_wr_i   = wr;
    req_addr_i = a;
    req_data_i = d;
    for (int k = 0; k < N; k++) begin
      if (en[k] && !m_pending[k]) begin
        m_pending[k] = 1'b1;
        acc_cyc[k]   = cyc + 1;
        r.wr   = wr[k];
        r.addr = a[k*AW +: AW];
        r.data = d[k*DW +: DW];
        req_q[k].push_back(r);
      end
    end
    @(posedge clk_i);
    #1;
    req_en_i = '0;
  endtask

  task automatic drain(input int budget);
    int b;
    b = budget;
    while (m_pending != '0 && b > 0) begin
      idle(1);
      b--;
    end
    idle(2);
    check("drain_model_pending", m_pending, '0);
    check("drain_busy", req_busy_o, '0);
  endtask

  task automatic set_knob(input int d, input bit fire, input logic [31:0] data);
    knob_set  = 1;
    knob_d    = d;
    knob_fire = fire;
    knob_data = data;
  endtask

  // Monitor + wrapper responder: samples on the falling edge
  initial begin : monitor
    int          cd;
    bit          cd_fire;
    logic [31:0] cd_data;
    logic [N-1:0] exp_b;
    exp_t        e;
    req_t        rq;
    int          owner, earliest, j, exp_g, d;
    bit          fire, spur;
    logic [31:0] rdata;
    cd = 0;
    cd_fire = 0;
    cd_data = '0;
    forever begin
      @(negedge clk_i);
      wrapper_valid_i = 1'b0;
      wrapper_data_i  = $urandom;
      if (cd > 0) begin
        cd--;
        if (cd == 0 && cd_fire) begin
          wrapper_valid_i = 1'b1;
          wrapper_data_i  = cd_data;
        end
      end
      if (!nrst_i) begin
        exp_q.delete();
        continue;
      end

      for (int k = 0; k < N; k++) exp_b[k] = m_pending[k] && (acc_cyc[k] <= cyc);
      check("busy", req_busy_o, exp_b);

      if (exp_q.size() > 0) begin
        check("wb_wr_stable", wrapper_wr_o, exp_q[0].rq.wr);
        check("wb_addr_stable", wrapper_addr_o, exp_q[0].rq.addr);
        check("wb_data_stable", wrapper_data_o, exp_q[0].rq.data);
      end

      if (req_valid_o != '0 || req_err_o != '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", {req_valid_o, req_err_o}, '0);
        end else begin
          e = exp_q.pop_front();
          check("valid_owner", req_valid_o, N'(1) << e.owner);
          check("err_flag", req_err_o, e.err ? (N'(1) << e.owner) : N'(0));
          check("rdata", req_data_o, e.data);
          check("done_cycle", cyc, e.done_cyc);
          m_pending[e.owner] = 1'b0;
          m_rr      = (e.owner + 1) % N;
          last_done = cyc;
        end
      end

      if (wrapper_en_o) begin
        if (exp_q.size() != 0) begin
          check("en_while_busy", wrapper_en_o, 1'b0);
        end else begin
          owner    = -1;
          earliest = 32'h7fff_ffff;
          for (int i = 0; i < N; i++) begin
            j = (m_rr + i) % N;
            if (owner < 0 && m_pending[j] && req_q[j].size() > 0 && acc_cyc[j] < cyc) owner = j;
            if (m_pending[j] && req_q[j].size() > 0 && acc_cyc[j] < earliest) earliest = acc_cyc[j];
          end
          if (owner < 0) begin
            check("issue_without_request", wrapper_en_o, 1'b0);
          end else begin
            exp_g = (last_done + 2 > earliest + 1) ? last_done + 2 : earliest + 1;
            check("issue_cycle", cyc, exp_g);
            rq = req_q[owner].pop_front();
            check("issue_wr", wrapper_wr_o, rq.wr);
            check("issue_addr", wrapper_addr_o, rq.addr);
            check("issue_data", wrapper_data_o, rq.data);
            if (knob_set) begin
              d = knob_d; fire = knob_fire; rdata = knob_data; spur = 0;
              knob_set = 0;
            end else begin
              d     = $urandom_range(1, 9);
              fire  = ($urandom_range(0, 9) != 0);
              rdata = $urandom;
              spur  = ($urandom_range(0, 4) == 0);
            end
            if (spur) wrapper_valid_i = 1'b1;
            e.owner    = owner;
            e.rq       = rq;
            e.err      = !(fire && d <= TO);
            e.data     = e.err ? 32'h0 : rdata;
            e.done_cyc = cyc + 1 + (e.err ? TO : d);
            exp_q.push_back(e);
            cd      = d;
            cd_fire = fire;
            cd_data = rdata;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    errors++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : stimulus
    bit seen;
    logic [N-1:0] en;
    logic [N-1:0] wr;
    logic [N*AW-1:0] a;
    logic [N*DW-1:0] d;

    repeat (2) @(posedge clk_i);
    #1;
    check("rst_outputs", {req_busy_o, req_valid_o, req_err_o, req_data_o, wrapper_wr_o,
                          wrapper_en_o, wrapper_addr_o, wrapper_data_o}, '0);
    #1 nrst_i = 1'b1;
    idle(2);

    // Single read from requester 0, checking issue latency and one-cycle enable
    set_knob(3, 1, 32'hDEADBEEF);
    drive(2'b01, 2'b00, {32'h0, 32'h0000_0010}, '0);
    check("en_lat_idle", wrapper_en_o, 1'b0);
    idle(1);
    check("en_lat_issue", wrapper_en_o, 1'b1);
    idle(1);
    check("en_single_cycle", wrapper_en_o, 1'b0);
    drain(40);

    // rr now 1: serve requester 1 so rr returns to 0, then simultaneous pair
    drive(2'b10, 2'b00, {32'h0000_0100, 32'h0}, '0);
    drain(40);
    drive(2'b11, 2'b00, {32'h0000_0204, 32'h0000_0200}, '0);
    drain(60);
    drive(2'b01, 2'b00, {32'h0, 32'h0000_0300}, '0);
    drain(40);
    drive(2'b11, 2'b00, {32'h0000_0404, 32'h0000_0400}, '0);
    drain(60);

    // Write from requester 1
    set_knob(4, 1, 32'hCAFE_F00D);
    drive(2'b10, 2'b10, {32'h0000_0020, 32'h0}, {32'h1234_5678, 32'h0});
    drain(40);

    // Timeout on the first granted, the other requester then proceeds
    set_knob(9, 0, 32'h0);
    drive(2'b11, 2'b01, {32'h0000_0504, 32'h0000_0500}, {32'h0, 32'h5555_AAAA});
    drain(80);

    // Duplicate pulses while busy and in the completion cycle are dropped
    set_knob(5, 1, 32'h0BAD_CAFE);
    drive(2'b01, 2'b00, {32'h0, 32'h0000_0600}, '0);
    idle(1);
    drive(2'b01, 2'b01, {32'h0, 32'h0000_0700}, {32'h0, 32'h1111_1111});
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (req_valid_o[0]) seen = 1;
      else idle(1);
    end
    check("dup_completion_seen", seen, 1'b1);
    drive(2'b01, 2'b01, {32'h0, 32'h0000_0800}, {32'h0, 32'h2222_2222});
    drive(2'b01, 2'b00, {32'h0, 32'h0000_0900}, '0);
    drain(40);

    // Reset in WAIT, with the wrapper still answering afterwards
    set_knob(9, 1, 32'h7777_7777);
    drive(2'b01, 2'b00, {32'h0, 32'h0000_0A00}, '0);
    idle(3);
    #2 nrst_i = 1'b0;
    #1;
    check("rst_async_outputs", {req_busy_o, req_valid_o, req_err_o, req_data_o, wrapper_wr_o,
                                wrapper_en_o, wrapper_addr_o, wrapper_data_o}, '0);
    m_pending = '0;
    for (int k = 0; k < N; k++) req_q[k].delete();
    m_rr      = 0;
    last_done = -10;
    @(posedge clk_i);
    #2 nrst_i = 1'b1;
    idle(14);
    drive(2'b10, 2'b00, {32'h0000_0B00, 32'h0}, '0);
    drain(40);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < N; k++) en[k] = ($urandom_range(0, 9) < 3);
      wr = N'($urandom);
      a  = {$urandom, $urandom};
      d  = {$urandom, $urandom};
      if (en != '0) drive(en, wr, a, d);
      else idle(1);
    end
    drain(300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
